// File: rtl/multdiv_seq_ctrl_if.sv
// Bus between the multiply/divide controller, its requester and the
// downstream 64-bit AQ register stage.
interface multdiv_seq_ctrl_if;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [63:0] aq_q;
  logic [63:0] aq_in;
  logic        aq_we;
  logic        aq_oe;
  logic [31:0] result;
  logic        exception;
  logic        data_ready;
  logic        busy;

  // Requester side plus the AQ register read-back path.
  modport master (
    output ctrl_mult, ctrl_div, data_a, data_b, aq_q,
    input  aq_in, aq_we, aq_oe, result, exception, data_ready, busy
  );

  // Controller side.
  modport slave (
    input  ctrl_mult, ctrl_div, data_a, data_b, aq_q,
    output aq_in, aq_we, aq_oe, result, exception, data_ready, busy
  );
endinterface

// File: rtl/multdiv_seq_ctrl.sv
// Sequential 32-bit signed multiply (radix-2 Booth) / divide (restoring)
// controller. The AQ image lives in the external AQ register; this block
// only computes the next image from the read-back value and drives the
// register's write/output enables.
module multdiv_seq_ctrl (
  input  logic                clk,
  input  logic                reset,
  multdiv_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIN} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_cnt;
  logic [31:0] r_m;
  logic [31:0] r_qinit;
  logic        r_is_div;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_dbz;
  logic        r_qm1;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_ready;
  logic        r_busy;

  logic        w_start;
  logic        w_b_zero;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  logic [31:0] w_a;
  logic [31:0] w_q;
  logic [31:0] w_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_sh;
  logic [32:0] w_t;
  logic [63:0] w_div_next;

  logic        w_aq_we;
  logic        w_aq_oe;
  logic [63:0] w_aq_in;

  assign w_start  = (r_state == S_IDLE) && (bus.ctrl_mult ^ bus.ctrl_div);
  assign w_b_zero = (bus.data_b == '0);
  assign w_abs_a  = bus.data_a[31] ? (32'd0 - bus.data_a) : bus.data_a;
  assign w_abs_b  = bus.data_b[31] ? (32'd0 - bus.data_b) : bus.data_b;

  assign w_a = bus.aq_q[63:32];
  assign w_q = bus.aq_q[31:0];

  // Booth step: add/subtract M on {Q0,q_m1}, then arithmetic shift of {A,Q}.
  always_comb begin
    w_sum = w_a;
    case ({w_q[0], r_qm1})
      2'b01:   w_sum = w_a + r_m;
      2'b10:   w_sum = w_a - r_m;
      default: w_sum = w_a;
    endcase
    w_mul_next = {w_sum[31], w_sum, w_q[31:1]};
  end

  // A < M <= 2^31 holds before every shift, so the shifted A fits in 32 bits.
  assign w_sh       = {bus.aq_q[62:0], 1'b0};
  assign w_t        = {1'b0, w_sh[63:32]} - {1'b0, r_m};
  assign w_div_next = w_t[32] ? w_sh : {w_t[31:0], w_sh[31:1], 1'b1};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and AQ register control decode.
  always_comb begin
    w_next  = r_state;
    w_aq_we = 1'b0;
    w_aq_oe = 1'b0;
    w_aq_in = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = (bus.ctrl_div && w_b_zero) ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        w_aq_we = 1'b1;
        w_aq_in = {32'h0, r_qinit};
        w_next  = S_ITER;
      end
      S_ITER: begin
        w_aq_we = 1'b1;
        w_aq_oe = 1'b1;
        w_aq_in = r_is_div ? w_div_next : w_mul_next;
        if (r_cnt == 5'd31) w_next = S_FIN;
      end
      S_FIN: begin
        w_aq_oe = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, step counter, Booth history bit and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_m      <= '0;
      r_qinit  <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dbz    <= 1'b0;
      r_qm1    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_div <= bus.ctrl_div;
            r_sign_a <= bus.data_a[31];
            r_sign_b <= bus.data_b[31];
            r_m      <= bus.ctrl_div ? w_abs_b : bus.data_a;
            r_qinit  <= bus.ctrl_div ? w_abs_a : bus.data_b;
            r_dbz    <= bus.ctrl_div && w_b_zero;
            r_busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
          r_qm1 <= 1'b0;
        end
        S_ITER: begin
          r_cnt <= r_cnt + 5'd1;
          if (!r_is_div) r_qm1 <= w_q[0];
        end
        S_FIN: begin
          if (r_dbz) begin
            r_result <= '0;
            r_exc    <= 1'b1;
          end else if (r_is_div) begin
            r_result <= (r_sign_a ^ r_sign_b) ? (32'd0 - w_q) : w_q;
            r_exc    <= 1'b0;
          end else begin
            r_result <= w_q;
            r_exc    <= (w_a != {32{w_q[31]}});
          end
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.aq_we      = w_aq_we;
  assign bus.aq_oe      = w_aq_oe;
  assign bus.aq_in      = w_aq_in;
  assign bus.result     = r_result;
  assign bus.exception  = r_exc;
  assign bus.data_ready = r_ready;
  assign bus.busy       = r_busy;

endmodule

// File: doc/multdiv_seq_ctrl.md
# multdiv_seq_ctrl

Sequential 32-bit signed multiply/divide controller that drives the 64-bit AQ register stage directly downstream of it. It loads the initial {A,Q} image, then for 32 cycles reads AQ back, computes one radix-2 Booth (multiply) or restoring-division step, and writes the new image. It finishes by extracting a 32-bit result with an exception flag. It owns all AQ write-enable and output-enable control; AQ storage lives only in the AQ register.

## Interface
Parameters: none (datapath fixed at 32-bit operands, 64-bit AQ).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- ctrl_mult  in  1  start signed multiply; sampled while ready_busy=0
- ctrl_div  in  1  start signed divide; sampled while ready_busy=0
- data_a  in  32  multiplicand / dividend, captured at start edge
- data_b  in  32  multiplier / divisor, captured at start edge
- aq_q  in  64  AQ register contents read back (A = [63:32], Q = [31:0])
- aq_in  out  64  next AQ image
- aq_we  out  1  AQ register write enable
- aq_oe  out  1  AQ register output enable
- result  out  32  product low word / quotient; held until next start
- exception  out  1  overflow or divide-by-zero; held with result
- data_ready  out  1  one-cycle pulse when result/exception are valid
- busy  out  1  operation in progress

## Operation
- States: IDLE, LOAD, ITER, FIN.
- IDLE: a start is accepted when exactly one of ctrl_mult/ctrl_div is 1. Both 1 or both 0 means no action.
  - Accepted start captures M, the operation type, and the sign bits, and sets busy=1.
  - Next state is LOAD, or FIN directly for divide-by-zero.
- LOAD: aq_we=1, aq_oe=0.
  - Multiply: aq_in={32'h0, data_b}, M=data_a, booth bit q_m1=0.
  - Divide: aq_in={32'h0, |data_a|}, M=|data_b|.
  - Counter is cleared to 0. Next state is ITER.
- ITER, one step per cycle: aq_oe=1, aq_we=1, and aq_in is a combinational function of aq_q.
  - Multiply: with A=aq_q[63:32], on {aq_q[0],q_m1} 01 compute A+M and on 10 compute A−M (32-bit wrap); otherwise A is unchanged.
  - Multiply, continued: arithmetically shift {A,Q,q_m1} right by 1 and register the new q_m1.
  - Divide: shift {A,Q} left by 1, then compute T = {1'b0,A} − {1'b0,M} in 33 bits.
  - Divide, no borrow: A=T[31:0] and Q[0]=1. Borrow: A is restored and Q[0]=0.
  - Counter increments each step. After step 31 (32 steps) the next state is FIN.
- FIN: aq_oe=1, aq_we=0.
  - Multiply: result=aq_q[31:0]. exception=1 iff aq_q[63:32] ≠ {32{aq_q[31]}}.
  - Divide: result = quotient aq_q[31:0], negated if sign_a≠sign_b. exception=0.
  - Divide-by-zero (data_b=0 at start): result=0, exception=1, and the AQ register is never written.
  - On the FIN edge result and exception are registered, data_ready pulses, busy clears, and the next state is IDLE.
- −2^31 / −1 gives result 32'h80000000 with exception=0.
- ctrl_mult/ctrl_div while busy are ignored, with no restart.

## Timing
- Reset (asynchronous, any state, including mid-ITER) forces:
  - state=IDLE, counter=0, M=0, q_m1=0
  - result=0, exception=0, data_ready=0, busy=0
  - aq_we=0, aq_oe=0, aq_in=0
- Start sampled on edge E0.
  - Normal operation: LOAD during cycle E0–E1, ITER for E1–E33 (32 writes, on E2..E33), FIN for E33–E34.
  - data_ready=1 for exactly the cycle after E34, and result is valid from E34.
  - Latency is 34 clocks for both multiply and divide.
- Divide-by-zero: FIN for cycle E0–E1, data_ready=1 after E1, latency 1.
- A new start is accepted on the edge following the data_ready cycle, or any later edge.
- aq_we is never asserted in IDLE or FIN. aq_oe is never asserted in IDLE or LOAD.
- data_a/data_b may change freely after E0.

## Test plan
- Multiply 7 × −3 (32'hFFFFFFFD), start at E0: result=32'hFFFFFFEB, exception=0, data_ready pulse after E34, exactly 33 aq_we cycles.
- Multiply 32'h00010000 × 32'h00010000: result=0, exception=1. Then −1 × −1: result=1, exception=0.
- Divide −7 / 2: result=32'hFFFFFFFD. Then 100 / 7: result=14. Both with exception=0 and latency 34.
- Divide 5 / 0: result=0, exception=1, data_ready after E1, aq_we never asserted.
- Reset pulse at E10 of a multiply: all outputs 0 immediately and no data_ready. A following 6 × 7 returns 42.
- ctrl_div asserted at E5 during a multiply, and ctrl_mult=ctrl_div=1 in IDLE: both ignored, with busy and result unaffected.
